// File: rtl/complex_mul_pkg.sv
// complex_mul_pkg: shared types, widths and elaboration checks for the handshaked complex multiplier
package complex_mul_pkg;
  typedef enum logic [2:0] {IDLE, M1, M2, M3, DONE} state_e;
  localparam int DEF_IN_W = 8;
  localparam int DEF_SUM_W = DEF_IN_W + 1;
  localparam int DEF_PROD_W = 2 * DEF_IN_W + 2;
  function automatic int sum_w(input int in_w);
    return in_w + 1;
  endfunction
  function automatic int prod_w(input int in_w);
    return 2 * in_w + 2;
  endfunction
  function automatic bit out_w_ok(input int in_w, input int out_w);
    return in_w >= 4 && in_w <= 24 && out_w >= 2 * in_w + 2;
  endfunction
endpackage

// File: rtl/cmul_shared_mult.sv
// cmul_shared_mult: single signed multiplier with operand mux selecting which 3-product term to form
module cmul_shared_mult #(
  parameter int SW = 9,
  parameter int PW = 18
) (
  input  logic [1:0]           sel_i,
  input  logic signed [SW-1:0] ar_i,
  input  logic signed [SW-1:0] ai_i,
  input  logic signed [SW-1:0] br_i,
  input  logic signed [SW-1:0] bi_i,
  output logic signed [PW-1:0] p_o
);
  logic signed [SW-1:0] x, y;
  // sel 0: ar*(br+bi), 1: (ar+ai)*bi, 2/3: (ai-ar)*br; every sum fits SW bits exactly
  always_comb begin
    x = sel_i == 2'd0 ? ar_i : sel_i == 2'd1 ? ar_i + ai_i : ai_i - ar_i;
    y = sel_i == 2'd0 ? br_i + bi_i : sel_i == 2'd1 ? bi_i : br_i;
    p_o = PW'(x) * PW'(y);
  end
endmodule

// File: rtl/complex_mul_hs.sv
// complex_mul_hs: valid/ready complex multiplier (A*B or A*conj(B)) iterating one multiplier over three cycles
module complex_mul_hs
  import complex_mul_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2 * IN_W + 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  ar,
  input  logic signed [IN_W-1:0]  ai,
  input  logic signed [IN_W-1:0]  br,
  input  logic signed [IN_W-1:0]  bi,
  input  logic                    conj_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] pr,
  output logic signed [OUT_W-1:0] pi,
  output logic                    busy
);
  localparam int SW = sum_w(IN_W);
  localparam int PW = prod_w(IN_W);
  if (!out_w_ok(IN_W, OUT_W)) begin : g_chk
    $error("complex_mul_hs: IN_W must be 4..24 and OUT_W >= 2*IN_W+2");
  end
  state_e state_q, state_d;
  logic signed [SW-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bie_q, bie_d;
  logic signed [PW-1:0] d1_q, d1_d, d2_q, d2_d, p, re, im;
  logic signed [OUT_W-1:0] pr_q, pr_d, pi_q, pi_d;
  logic ov_q, ov_d, accept;
  logic [1:0] sel;
  cmul_shared_mult #(.SW(SW), .PW(PW)) u_mult (
    .sel_i(sel), .ar_i(ar_q), .ai_i(ai_q), .br_i(br_q), .bi_i(bie_q), .p_o(p)
  );
  assign in_ready  = ~rst & (state_q == IDLE | (state_q == DONE & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = ov_q;
  assign pr        = pr_q;
  assign pi        = pi_q;
  assign busy      = state_q != IDLE;
  // conj negation is done at SW bits so negating the most negative input cannot wrap
  always_comb begin
    sel = state_q == M2 ? 2'd1 : state_q == M3 ? 2'd2 : 2'd0;
    re = d1_q - d2_q;
    im = d1_q + p;
    state_d = accept ? M1 : state_q == M1 ? M2 : state_q == M2 ? M3 : state_q == M3 ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
    ar_d = accept ? SW'(ar) : ar_q;
    ai_d = accept ? SW'(ai) : ai_q;
    br_d = accept ? SW'(br) : br_q;
    bie_d = accept ? (conj_i ? -SW'(bi) : SW'(bi)) : bie_q;
    d1_d = state_q == M1 ? p : d1_q;
    d2_d = state_q == M2 ? p : d2_q;
    pr_d = state_q == M3 ? OUT_W'(re) : pr_q;
    pi_d = state_q == M3 ? OUT_W'(im) : pi_q;
    ov_d = state_q == M3 ? 1'b1 : (state_q == DONE && out_ready) ? 1'b0 : ov_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bie_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      pr_q <= '0;
      pi_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q <= ar_d;
      ai_q <= ai_d;
      br_q <= br_d;
      bie_q <= bie_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      pr_q <= pr_d;
      pi_q <= pi_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_complex_mul_hs.sv
// tb_complex_mul_hs: randomized self-checking bench against a plain 4-multiplication complex product model
module tb_complex_mul_hs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;

  logic signed [7:0] a_r8, a_i8, b_r8, b_i8;
  logic c8, iv8, ir8, ov8, or8, busy8;
  logic signed [18:0] pr8, pi8;
  complex_mul_hs #(.IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .ar(a_r8), .ai(a_i8), .br(b_r8), .bi(b_i8),
    .conj_i(c8), .out_valid(ov8), .out_ready(or8), .pr(pr8), .pi(pi8), .busy(busy8)
  );

  logic iv_s, or_s, c_s;
  logic signed [3:0] a_r4, a_i4, b_r4, b_i4;
  logic ir4, ov4, busy4;
  logic signed [10:0] pr4, pi4;
  complex_mul_hs #(.IN_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir4), .ar(a_r4), .ai(a_i4), .br(b_r4), .bi(b_i4),
    .conj_i(c_s), .out_valid(ov4), .out_ready(or_s), .pr(pr4), .pi(pi4), .busy(busy4)
  );
  logic signed [11:0] a_r12, a_i12, b_r12, b_i12;
  logic ir12, ov12, busy12;
  logic signed [26:0] pr12, pi12;
  complex_mul_hs #(.IN_W(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir12), .ar(a_r12), .ai(a_i12), .br(b_r12), .bi(b_i12),
    .conj_i(c_s), .out_valid(ov12), .out_ready(or_s), .pr(pr12), .pi(pi12), .busy(busy12)
  );

  function automatic longint cm(input longint xr, xi, yr, yi, input bit c, input bit imag);
    longint yi_e;
    yi_e = c ? -yi : yi;
    return imag ? xr * yi_e + xi * yr : xr * yr - xi * yi_e;
  endfunction

  task automatic send8(input longint xr, xi, yr, yi, input bit c);
    int n = 0;
    a_r8 = 8'(xr); a_i8 = 8'(xi); b_r8 = 8'(yr); b_i8 = 8'(yi); c8 = c; iv8 = 1'b1;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (ir8 !== 1'b1) begin fails++; $display("FAIL send8_ready got=%b expected=1", ir8); end
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (ov8 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    int cyc;
    bit seen = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ov8, ir8, busy8} !== 3'b000 || pr8 !== 0 || pi8 !== 0)
      begin fails++; $display("FAIL reset_state ov/ir/busy=%b pr=%0d pi=%0d expected 000 0 0", {ov8, ir8, busy8}, pr8, pi8); end
    checks++;
    if ({ov4, ir4, ov12, ir12} !== 4'b0000)
      begin fails++; $display("FAIL reset_state_sweep got=%b expected=0000", {ov4, ir4, ov12, ir12}); end
    rst = 1'b0;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b expected=1", ir8); end
    @(negedge clk);
    send8(3, 4, 1, 2, 0);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL mid_op_busy got=%b expected=1", busy8); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, ov8, ir8} !== 3'b000) begin fails++; $display("FAIL async_reset busy/ov/ir=%b expected=000", {busy8, ov8, ir8}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (ov8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin fails++; $display("FAIL reset_discard out_valid_or_busy_seen=1 expected=0"); end
    send8(3, 4, 1, 2, 0);
    wait8(cyc);
    checks++;
    if (ov8 !== 1'b1 || pr8 !== -19'sd5 || pi8 !== 19'sd10)
      begin fails++; $display("FAIL post_reset_result ov=%b pr=%0d pi=%0d expected 1 -5 10", ov8, pr8, pi8); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit bad = 1'b0;
    or8 = 1'b1;
    send8(3, 4, 1, 2, 0);
    checks++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b expected=1", busy8); end
    for (int i = 0; i < 3; i++) begin
      if (ir8 !== 1'b0 || ov8 !== 1'b0) bad = 1'b1;
      if (i < 2) @(negedge clk);
    end
    checks++;
    if (bad) begin fails++; $display("FAIL basic_in_ready_low in_ready_or_out_valid_high=1 expected=0"); end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b1 || pr8 !== -19'sd5 || pi8 !== 19'sd10 || ir8 !== 1'b1)
      begin fails++; $display("FAIL basic_latency ov=%b ir=%b pr=%0d pi=%0d expected 1 1 -5 10", ov8, ir8, pr8, pi8); end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0)
      begin fails++; $display("FAIL basic_drain ov=%b busy=%b expected 0 0", ov8, busy8); end
  endtask

  task automatic test_conj;
    longint v[4][5] = '{'{3, 4, 1, 2, 1}, '{-128, -128, -128, -128, 1}, '{-128, -128, -128, -128, 0}, '{127, -128, -128, 127, 1}};
    longint er[4] = '{11, 32768, 0, 0};
    longint ei[4] = '{-2, 0, 32768, 0};
    int cyc;
    er[3] = cm(127, -128, -128, 127, 1, 0);
    ei[3] = cm(127, -128, -128, 127, 1, 1);
    for (int i = 0; i < 4; i++) begin
      send8(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4][0]);
      wait8(cyc);
      checks++;
      if (ov8 !== 1'b1 || longint'(pr8) !== er[i] || longint'(pi8) !== ei[i])
        begin fails++; $display("FAIL conj_%0d ov=%b pr=%0d pi=%0d expected 1 %0d %0d", i, ov8, pr8, pi8, er[i], ei[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    longint xr, xi, yr, yi, er, ei;
    logic signed [18:0] hr, hi;
    int cyc;
    bit bad = 1'b0;
    xr = longint'($signed(8'($urandom))); xi = longint'($signed(8'($urandom)));
    yr = longint'($signed(8'($urandom))); yi = longint'($signed(8'($urandom)));
    er = cm(xr, xi, yr, yi, 0, 0); ei = cm(xr, xi, yr, yi, 0, 1);
    or8 = 1'b0;
    send8(xr, xi, yr, yi, 0);
    wait8(cyc);
    checks++;
    if (cyc !== 3 || longint'(pr8) !== er || longint'(pi8) !== ei)
      begin fails++; $display("FAIL bp_result cyc=%0d pr=%0d pi=%0d expected 3 %0d %0d", cyc, pr8, pi8, er, ei); end
    hr = pr8; hi = pi8;
    for (int i = 0; i < 5; i++) begin
      iv8 = (i % 2 == 0);
      a_r8 = 8'($urandom); b_i8 = 8'($urandom);
      @(negedge clk);
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || pr8 !== hr || pi8 !== hi) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("FAIL bp_hold ov=%b ir=%b pr=%0d pi=%0d expected 1 0 %0d %0d", ov8, ir8, pr8, pi8, hr, hi); end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || pr8 !== hr || pi8 !== hi)
      begin fails++; $display("FAIL bp_release ov=%b busy=%b pr=%0d pi=%0d expected 0 0 %0d %0d", ov8, busy8, pr8, pi8, hr, hi); end
    bad = 1'b0;
    repeat (4) begin @(negedge clk); if (ov8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad) begin fails++; $display("FAIL bp_no_capture ov_or_busy_seen=1 expected=0"); end
  endtask

  task automatic test_back_to_back;
    longint qr[$], qi[$];
    int sent = 0, got = 0, last = -1, cyc = 0;
    bit gap_bad = 1'b0, idle_bad = 1'b0;
    or8 = 1'b1;
    while (got < 10 && cyc < 80) begin
      if (ov8 === 1'b1) begin
        checks++;
        if (qr.size() == 0 || longint'(pr8) !== qr[0] || longint'(pi8) !== qi[0])
          begin fails++; $display("FAIL b2b_result_%0d pr=%0d pi=%0d expected %0d %0d", got, pr8, pi8, qr.size() ? qr[0] : 0, qi.size() ? qi[0] : 0); end
        if (qr.size() != 0) begin void'(qr.pop_front()); void'(qi.pop_front()); end
        if (last >= 0 && cyc - last != 4) gap_bad = 1'b1;
        last = cyc;
        got++;
      end
      if (sent > 0 && got < 10 && busy8 !== 1'b1) idle_bad = 1'b1;
      if (ir8 === 1'b1 && sent < 10) begin
        a_r8 = 8'($urandom); a_i8 = 8'($urandom); b_r8 = 8'($urandom); b_i8 = 8'($urandom); c8 = 1'($urandom);
        qr.push_back(cm(longint'(a_r8), longint'(a_i8), longint'(b_r8), longint'(b_i8), c8, 0));
        qi.push_back(cm(longint'(a_r8), longint'(a_i8), longint'(b_r8), longint'(b_i8), c8, 1));
        iv8 = 1'b1;
        sent++;
      end else if (ir8 === 1'b1) iv8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    iv8 = 1'b0;
    checks++;
    if (got != 10 || gap_bad || idle_bad)
      begin fails++; $display("FAIL b2b_stream got=%0d gap_bad=%b idle_bad=%b expected 10 0 0", got, gap_bad, idle_bad); end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int n;
    longint v[4];
    or_s = 1'b1;
    for (int idx = 0; idx < 1162; idx++) begin
      if (idx < 162) begin
        int t = idx / 2;
        c_s = 1'(idx % 2);
        for (int k = 0; k < 4; k++) begin v[k] = longint'(t % 3) - 1; t = t / 3; end
        a_r4 = 4'(v[0]); a_i4 = 4'(v[1]); b_r4 = 4'(v[2]); b_i4 = 4'(v[3]);
        a_r12 = 12'(v[0]); a_i12 = 12'(v[1]); b_r12 = 12'(v[2]); b_i12 = 12'(v[3]);
      end else begin
        c_s = 1'($urandom);
        a_r4 = 4'($urandom); a_i4 = 4'($urandom); b_r4 = 4'($urandom); b_i4 = 4'($urandom);
        a_r12 = 12'($urandom); a_i12 = 12'($urandom); b_r12 = 12'($urandom); b_i12 = 12'($urandom);
      end
      iv_s = 1'b1;
      n = 0;
      while ((ir4 !== 1'b1 || ir12 !== 1'b1) && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      iv_s = 1'b0;
      n = 0;
      while (ov4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (ov4 !== 1'b1 || ov12 !== 1'b1 ||
          longint'(pr4) !== cm(longint'(a_r4), longint'(a_i4), longint'(b_r4), longint'(b_i4), c_s, 0) ||
          longint'(pi4) !== cm(longint'(a_r4), longint'(a_i4), longint'(b_r4), longint'(b_i4), c_s, 1))
        begin fails++; $display("FAIL sweep4_%0d ov=%b pr=%0d pi=%0d expected 1 %0d %0d", idx, ov4, pr4, pi4,
          cm(longint'(a_r4), longint'(a_i4), longint'(b_r4), longint'(b_i4), c_s, 0),
          cm(longint'(a_r4), longint'(a_i4), longint'(b_r4), longint'(b_i4), c_s, 1)); end
      checks++;
      if (longint'(pr12) !== cm(longint'(a_r12), longint'(a_i12), longint'(b_r12), longint'(b_i12), c_s, 0) ||
          longint'(pi12) !== cm(longint'(a_r12), longint'(a_i12), longint'(b_r12), longint'(b_i12), c_s, 1))
        begin fails++; $display("FAIL sweep12_%0d pr=%0d pi=%0d expected %0d %0d", idx, pr12, pi12,
          cm(longint'(a_r12), longint'(a_i12), longint'(b_r12), longint'(b_i12), c_s, 0),
          cm(longint'(a_r12), longint'(a_i12), longint'(b_r12), longint'(b_i12), c_s, 1)); end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; c8 = 1'b0; a_r8 = '0; a_i8 = '0; b_r8 = '0; b_i8 = '0;
    iv_s = 1'b0; or_s = 1'b1; c_s = 1'b0;
    a_r4 = '0; a_i4 = '0; b_r4 = '0; b_i4 = '0; a_r12 = '0; a_i12 = '0; b_r12 = '0; b_i12 = '0;
    test_reset;
    test_basic;
    test_conj;
    test_backpressure;
    test_back_to_back;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
